// File: rtl/pipe_hazard_ctr_pkg.sv
// pipe_hazard_ctr_pkg: shared constants for the hazard scheduler.
// Forwarding select codes and MDU sequencer state encodings.
package pipe_hazard_ctr_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/pipe_hazard_ctr_mdu_seq.sv
// pipe_hazard_ctr_mdu_seq: IDLE/RUN sequencer for the fixed-latency MDU.
// Ports: clk, rst (async high), id_is_mdu, hold, flush in; go, mdu_start, mdu_busy, in_run out.
module pipe_hazard_ctr_mdu_seq
  import pipe_hazard_ctr_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic id_is_mdu,
  input  logic hold,
  input  logic flush,
  output logic go,
  output logic mdu_start,
  output logic mdu_busy,
  output logic in_run
);

  localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 1);

  logic [0:0] state;
  logic [3:0] cnt;

  assign in_run    = (state == ST_RUN);
  assign go        = !in_run && id_is_mdu && !hold && !flush;
  assign mdu_start = go;
  assign mdu_busy  = in_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      unique case (1'b1)
        !in_run: begin
          if (go) begin
            state <= ST_RUN;
            cnt   <= CNT_INIT;
          end
        end
        in_run: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctr.sv
// pipe_hazard_ctr: forwarding, load-use stall, branch flush, MDU sequencing.
// Ports: ID/EX/MEM hazard inputs; fwd_a/b, pc_stall, id_bubble, if_flush, mdu_*, perf counters.
// Macro HAZ_PERF_CNT_EN builds the saturating stall/flush counters.
module pipe_hazard_ctr
  import pipe_hazard_ctr_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_mdu,
  input  logic             id_is_hilo,
  input  logic             ex_wreg,
  input  logic [REG_W-1:0] ex_destR,
  input  logic             ex_mem2reg,
  input  logic             mem_wreg,
  input  logic [REG_W-1:0] mem_destR,
  input  logic             ex_branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_stall,
  output logic             id_bubble,
  output logic             if_flush,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_cycles
);

  logic ex_nz;
  logic mem_nz;
  logic ex_alu;
  logic lu;
  logic mdu_hz;
  logic in_run;
  logic go;

  assign ex_nz  = ex_wreg && (ex_destR != '0);
  assign mem_nz = mem_wreg && (mem_destR != '0);
  assign ex_alu = ex_nz && !ex_mem2reg;

  always_comb begin
    fwd_a = FWD_REG;
    if (id_use_rs && ex_alu && ex_destR == id_rs) begin
      fwd_a = FWD_EX;
    end else if (id_use_rs && mem_nz && mem_destR == id_rs) begin
      fwd_a = FWD_MEM;
    end
  end

  always_comb begin
    fwd_b = FWD_REG;
    if (id_use_rt && ex_alu && ex_destR == id_rt) begin
      fwd_b = FWD_EX;
    end else if (id_use_rt && mem_nz && mem_destR == id_rt) begin
      fwd_b = FWD_MEM;
    end
  end

  assign lu = ex_nz && ex_mem2reg &&
              ((id_use_rs && ex_destR == id_rs) ||
               (id_use_rt && ex_destR == id_rt));

  assign mdu_hz    = in_run && (id_is_mdu || id_is_hilo);
  assign pc_stall  = !ex_branch_taken && (lu || mdu_hz);
  assign id_bubble = ex_branch_taken || lu || mdu_hz;
  assign if_flush  = ex_branch_taken;

  pipe_hazard_ctr_mdu_seq #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu_seq (
    .clk      (clk),
    .rst      (rst),
    .id_is_mdu(id_is_mdu),
    .hold     (pc_stall),
    .flush    (ex_branch_taken),
    .go       (go),
    .mdu_start(mdu_start),
    .mdu_busy (mdu_busy),
    .in_run   (in_run)
  );

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (pc_stall && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (if_flush && flush_cycles != '1) begin
        flush_cycles <= flush_cycles + 32'd1;
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctr.sv
// tb_pipe_hazard_ctr: directed checks of forwarding, stalls, flush, MDU and reset.
// Counter expectations follow HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctr;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_is_mdu;
  logic       id_is_hilo;
  logic       ex_wreg;
  logic [4:0] ex_destR;
  logic       ex_mem2reg;
  logic       mem_wreg;
  logic [4:0] mem_destR;
  logic       ex_branch_taken;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       pc_stall;
  logic       id_bubble;
  logic       if_flush;
  logic       mdu_start;
  logic       mdu_busy;
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;

  int checks;
  int failures;
  logic [31:0] exp_stall;
  logic [31:0] exp_flush;

  pipe_hazard_ctr #(
    .MDU_LAT(4),
    .REG_W  (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_is_mdu      (id_is_mdu),
    .id_is_hilo     (id_is_hilo),
    .ex_wreg        (ex_wreg),
    .ex_destR       (ex_destR),
    .ex_mem2reg     (ex_mem2reg),
    .mem_wreg       (mem_wreg),
    .mem_destR      (mem_destR),
    .ex_branch_taken(ex_branch_taken),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .pc_stall       (pc_stall),
    .id_bubble      (id_bubble),
    .if_flush       (if_flush),
    .mdu_start      (mdu_start),
    .mdu_busy       (mdu_busy),
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs = 5'd0;
    id_rt = 5'd0;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    id_is_mdu = 1'b0;
    id_is_hilo = 1'b0;
    ex_wreg = 1'b0;
    ex_destR = 5'd0;
    ex_mem2reg = 1'b0;
    mem_wreg = 1'b0;
    mem_destR = 5'd0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_stall = 32'd0;
    exp_flush = 32'd0;
    rst = 1'b1;
    clr();
    #3;
    chk("rst_busy", 32'(mdu_busy), 32'd0);
    chk("rst_start", 32'(mdu_start), 32'd0);
    chk("rst_stall", 32'(pc_stall), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_scnt", stall_cycles, 32'd0);
    chk("rst_fcnt", flush_cycles, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();

    clr();
    id_rs = 5'd3; id_use_rs = 1'b1;
    ex_wreg = 1'b1; ex_destR = 5'd3;
    #2;
    chk("fwd_ex_a", 32'(fwd_a), 32'd1);
    chk("fwd_ex_b", 32'(fwd_b), 32'd0);
    chk("fwd_ex_stall", 32'(pc_stall), 32'd0);
    tick();

    clr();
    id_rs = 5'd3; id_use_rs = 1'b1;
    mem_wreg = 1'b1; mem_destR = 5'd3;
    #2;
    chk("fwd_mem_a", 32'(fwd_a), 32'd2);
    tick();

    clr();
    id_rs = 5'd3; id_use_rs = 1'b1;
    id_rt = 5'd3; id_use_rt = 1'b1;
    ex_wreg = 1'b1; ex_destR = 5'd3;
    mem_wreg = 1'b1; mem_destR = 5'd3;
    #2;
    chk("fwd_prio_a", 32'(fwd_a), 32'd1);
    chk("fwd_prio_b", 32'(fwd_b), 32'd1);
    tick();

    clr();
    id_rt = 5'd5; id_use_rt = 1'b1;
    ex_wreg = 1'b1; ex_mem2reg = 1'b1; ex_destR = 5'd5;
    #2;
    chk("lu_stall", 32'(pc_stall), 32'd1);
    chk("lu_bubble", 32'(id_bubble), 32'd1);
    chk("lu_fwd_b", 32'(fwd_b), 32'd0);
    chk("lu_flush", 32'(if_flush), 32'd0);
    if (PERF) exp_stall = exp_stall + 32'd1;
    tick();

    clr();
    id_rt = 5'd5; id_use_rt = 1'b1;
    mem_wreg = 1'b1; mem_destR = 5'd5;
    #2;
    chk("lu_next_fwd_b", 32'(fwd_b), 32'd2);
    chk("lu_next_stall", 32'(pc_stall), 32'd0);
    chk("lu_next_bubble", 32'(id_bubble), 32'd0);
    tick();

    clr();
    id_use_rs = 1'b1; id_use_rt = 1'b1;
    ex_wreg = 1'b1; ex_mem2reg = 1'b1;
    mem_wreg = 1'b1;
    #2;
    chk("r0_stall", 32'(pc_stall), 32'd0);
    chk("r0_fwd_a", 32'(fwd_a), 32'd0);
    chk("r0_fwd_b", 32'(fwd_b), 32'd0);
    chk("scnt_after_lu", stall_cycles, exp_stall);
    tick();

    clr();
    id_is_mdu = 1'b1;
    #2;
    chk("mdu_start", 32'(mdu_start), 32'd1);
    chk("mdu_busy0", 32'(mdu_busy), 32'd0);
    chk("mdu_nostall", 32'(pc_stall), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      clr();
      id_is_hilo = 1'b1;
      #2;
      chk($sformatf("run_busy%0d", i), 32'(mdu_busy), 32'd1);
      chk($sformatf("run_stall%0d", i), 32'(pc_stall), 32'd1);
      chk($sformatf("run_bubble%0d", i), 32'(id_bubble), 32'd1);
      chk($sformatf("run_start%0d", i), 32'(mdu_start), 32'd0);
      if (PERF) exp_stall = exp_stall + 32'd1;
      tick();
    end
    clr();
    id_is_hilo = 1'b1;
    #2;
    chk("done_busy", 32'(mdu_busy), 32'd0);
    chk("done_stall", 32'(pc_stall), 32'd0);
    chk("scnt_after_mdu", stall_cycles, exp_stall);
    tick();

    clr();
    id_rs = 5'd7; id_use_rs = 1'b1;
    ex_wreg = 1'b1; ex_mem2reg = 1'b1; ex_destR = 5'd7;
    id_is_mdu = 1'b1;
    ex_branch_taken = 1'b1;
    #2;
    chk("br_flush", 32'(if_flush), 32'd1);
    chk("br_bubble", 32'(id_bubble), 32'd1);
    chk("br_stall", 32'(pc_stall), 32'd0);
    chk("br_nostart", 32'(mdu_start), 32'd0);
    if (PERF) exp_flush = exp_flush + 32'd1;
    tick();
    clr();
    #2;
    chk("br_scnt", stall_cycles, exp_stall);
    chk("br_fcnt", flush_cycles, exp_flush);
    chk("br_idle", 32'(mdu_busy), 32'd0);
    tick();

    clr();
    id_is_mdu = 1'b1;
    #2;
    chk("rr_start", 32'(mdu_start), 32'd1);
    tick();
    clr();
    tick();
    chk("rr_busy_pre", 32'(mdu_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_busy_async", 32'(mdu_busy), 32'd0);
    chk("rr_scnt", stall_cycles, 32'd0);
    chk("rr_fcnt", flush_cycles, 32'd0);
    exp_stall = 32'd0;
    exp_flush = 32'd0;
    #1 rst = 1'b0;
    tick();

    clr();
    id_is_mdu = 1'b1;
    #2;
    chk("re_start", 32'(mdu_start), 32'd1);
    chk("re_busy0", 32'(mdu_busy), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      clr();
      if (i == 1) ex_branch_taken = 1'b1;
      #2;
      chk($sformatf("re_busy%0d", i), 32'(mdu_busy), 32'd1);
      if (i == 1) begin
        chk("re_br_flush", 32'(if_flush), 32'd1);
        if (PERF) exp_flush = exp_flush + 32'd1;
      end
      tick();
    end
    clr();
    #2;
    chk("re_done", 32'(mdu_busy), 32'd0);
    chk("re_fcnt", flush_cycles, exp_flush);
    chk("re_scnt", stall_cycles, exp_stall);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
